// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the EX stage and the iterative mul/div sequencer.
//   start/op/a/b : mul/div request from EX (op 00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   mfhilo       : EX instruction reads HI or LO
//   flush        : squash the EX instruction and abort any in-flight operation
//   stall        : hold the front of the pipeline (combinational)
//   busy/done/dz : sequencer status; done pulses for one cycle when HI/LO update
//   hi/lo        : HI and LO registers
interface muldiv_seq_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        mfhilo;
   logic        flush;
   logic        stall;
   logic        busy;
   logic        done;
   logic        dz;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, a, b, mfhilo, flush,
      input  stall, busy, done, dz, hi, lo
   );

   modport slave (
      input  start, op, a, b, mfhilo, flush,
      output stall, busy, done, dz, hi, lo
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer sharing the EX stage with the ALU.
// 32-step shift-add multiply or restoring divide, then a sign fixup cycle
// that writes HI/LO. Stalls the pipeline while a later mul/div or MFHI/MFLO
// would otherwise see a busy unit.
//   clk  : pipeline clock
//   clrn : asynchronous active-low reset
//   bus  : request/status/result bundle (slave side)
module muldiv_seq (
   input logic         clk,
   input logic         clrn,
   muldiv_seq_if.slave bus
);
   localparam int unsigned W  = 32;
   localparam int unsigned CW = 6;
   localparam logic [CW-1:0] LAST = CW'(31);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [1:0]      op_q, op_nxt;
   logic            sa_q, sa_nxt;
   logic            sb_q, sb_nxt;
   logic [W-1:0]    araw_q, araw_nxt;
   logic [W-1:0]    opd_q, opd_nxt;
   logic [W-1:0]    acc_hi_q, acc_hi_nxt;
   logic [W-1:0]    acc_lo_q, acc_lo_nxt;
   logic [W-1:0]    hi_q, hi_nxt;
   logic [W-1:0]    lo_q, lo_nxt;
   logic            dz_q, dz_nxt;
   logic            done_q, done_nxt;
   logic            busy_q;

   // helper datapath terms
   logic            neg_a, neg_b;
   logic [W-1:0]    abs_a, abs_b;
   logic [W:0]      mul_sum;
   logic [W:0]      rem_sh;
   logic            rem_ge;
   logic [W-1:0]    rem_sub;
   logic [2*W-1:0]  prod, prod_fix;
   logic [W-1:0]    quo_fix, rem_fix;

   // State register
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; flush wins over everything, including a new start
   always_comb begin
      state_nxt = state;
      if (bus.flush) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Datapath and output next values
   always_comb begin
      cnt_nxt    = cnt;
      op_nxt     = op_q;
      sa_nxt     = sa_q;
      sb_nxt     = sb_q;
      araw_nxt   = araw_q;
      opd_nxt    = opd_q;
      acc_hi_nxt = acc_hi_q;
      acc_lo_nxt = acc_lo_q;
      hi_nxt     = hi_q;
      lo_nxt     = lo_q;
      dz_nxt     = dz_q;
      done_nxt   = 1'b0;

      neg_a = bus.op[0] & bus.a[W-1];
      neg_b = bus.op[0] & bus.b[W-1];
      abs_a = neg_a ? W'(-bus.a) : bus.a;
      abs_b = neg_b ? W'(-bus.b) : bus.b;

      // Multiply step: conditional add into the upper half, 65-bit shift right
      mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : {(W+1){1'b0}});

      // Divide step: shifted remainder is 33 bits wide before the trial subtract
      rem_sh  = {acc_hi_q, acc_lo_q[W-1]};
      rem_ge  = (rem_sh >= {1'b0, opd_q});
      rem_sub = W'(rem_sh - {1'b0, opd_q});

      prod     = {acc_hi_q, acc_lo_q};
      prod_fix = (sa_q ^ sb_q) ? (2*W)'(-prod) : prod;
      quo_fix  = (sa_q ^ sb_q) ? W'(-acc_lo_q) : acc_lo_q;
      rem_fix  = sa_q ? W'(-acc_hi_q) : acc_hi_q;

      if (!bus.flush) begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  op_nxt     = bus.op;
                  sa_nxt     = neg_a;
                  sb_nxt     = neg_b;
                  araw_nxt   = bus.a;
                  cnt_nxt    = '0;
                  acc_hi_nxt = '0;
                  if (!bus.op[1]) begin
                     opd_nxt    = abs_a;   // multiplicand
                     acc_lo_nxt = abs_b;   // multiplier shifts out of the low half
                  end else begin
                     opd_nxt    = abs_b;   // divisor
                     acc_lo_nxt = abs_a;   // dividend becomes the quotient in place
                  end
               end
            end
            RUN: begin
               cnt_nxt = cnt + CW'(1);
               if (!op_q[1]) begin
                  acc_hi_nxt = mul_sum[W:1];
                  acc_lo_nxt = {mul_sum[0], acc_lo_q[W-1:1]};
               end else begin
                  acc_hi_nxt = rem_ge ? rem_sub : rem_sh[W-1:0];
                  acc_lo_nxt = {acc_lo_q[W-2:0], rem_ge};
               end
            end
            FIX: begin
               done_nxt = 1'b1;
               dz_nxt   = 1'b0;
               if (!op_q[1]) begin
                  hi_nxt = prod_fix[2*W-1:W];
                  lo_nxt = prod_fix[W-1:0];
               end else if (opd_q == '0) begin
                  hi_nxt = araw_q;
                  lo_nxt = '1;
                  dz_nxt = 1'b1;
               end else begin
                  hi_nxt = rem_fix;
                  lo_nxt = quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cnt      <= '0;
         op_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         araw_q   <= '0;
         opd_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         dz_q     <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         op_q     <= op_nxt;
         sa_q     <= sa_nxt;
         sb_q     <= sb_nxt;
         araw_q   <= araw_nxt;
         opd_q    <= opd_nxt;
         acc_hi_q <= acc_hi_nxt;
         acc_lo_q <= acc_lo_nxt;
         hi_q     <= hi_nxt;
         lo_q     <= lo_nxt;
         dz_q     <= dz_nxt;
         done_q   <= done_nxt;
         busy_q   <= (state_nxt != IDLE);
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.dz    = dz_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   // Combinational so a waiting request is released in the same cycle the unit goes idle
   assign bus.stall = busy_q & (bus.start | bus.mfhilo);

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: table of directed vectors, random vectors against a
// reference model, and hand-written stall/flush/reset sequences. Expected
// results go into a scoreboard queue at issue and are popped on done.
module tb_muldiv_seq;
   logic clk;
   logic clrn;
   muldiv_seq_if bus ();

   muldiv_seq dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      exp_t        e;
   } vec_t;

   exp_t sb[$];
   exp_t last;
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, req);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      longint      sa, sbv, q, r;
      logic [63:0] p;
      e.dz = 1'b0;
      e.hi = '0;
      e.lo = '0;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      case (op)
         2'b00: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
         2'b01: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
         default: begin
            if (b == 32'd0) begin
               e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
            end else if (op == 2'b10) begin
               e.lo = a / b; e.hi = a % b;
            end else begin
               q = sa / sbv; r = sa % sbv;
               e.lo = 32'(q); e.hi = 32'(r);
            end
         end
      endcase
      return e;
   endfunction

   // Present a request, take the accept edge, then scramble the operands.
   // Returns at the negedge of the first cycle after accept.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input bit push);
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      if (push) sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
   endtask

   // Wait (bounded) for done; lat counts cycles after accept, stalls counts stall cycles before done
   task automatic wait_done(input string name, output int lat, output int stalls);
      lat = 1;
      stalls = 0;
      while (!bus.done && lat < 60) begin
         if (bus.stall) stalls++;
         @(negedge clk);
         lat++;
      end
      chk({name, "_done_seen"}, 64'(bus.done), 64'd1);
   endtask

   task automatic check_result(input string name);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL %s_scoreboard actual=empty expected=entry", name);
         return;
      end
      checks--;
      e = sb.pop_front();
      chk({name, "_hi"}, 64'(bus.hi), 64'(e.hi));
      chk({name, "_lo"}, 64'(bus.lo), 64'(e.lo));
      chk({name, "_dz"}, 64'(bus.dz), 64'(e.dz));
      last = e;
   endtask

   vec_t vecs[10];

   initial begin
      int    lat, stalls;
      bit    seen;
      exp_t  e;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'hFFFF_FFFE, 32'h0000_0001, 1'b0}};
      vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'd5,         '{32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0}};
      vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}};
      vecs[3] = '{2'b10, 32'h1234_5678, 32'd0,         '{32'h1234_5678, 32'hFFFF_FFFF, 1'b1}};
      vecs[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h0000_0000, 32'h8000_0000, 1'b0}};
      vecs[5] = '{2'b10, 32'd100,       32'd7,         '{32'd2,         32'd14,        1'b0}};
      vecs[6] = '{2'b01, 32'h8000_0000, 32'h8000_0000, '{32'h4000_0000, 32'h0000_0000, 1'b0}};
      vecs[7] = '{2'b11, 32'd7,         32'hFFFF_FFFE, '{32'd1,         32'hFFFF_FFFD, 1'b0}};
      vecs[8] = '{2'b11, 32'hFFFF_FFFB, 32'd0,         '{32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1}};
      vecs[9] = '{2'b00, 32'h0001_0000, 32'h0001_0000, '{32'h0000_0001, 32'h0000_0000, 1'b0}};

      clrn       = 1'b0;
      bus.start  = 1'b0;
      bus.op     = 2'b00;
      bus.a      = '0;
      bus.b      = '0;
      bus.mfhilo = 1'b0;
      bus.flush  = 1'b0;
      repeat (3) @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);
      chk("reset_hi",    64'(bus.hi),    64'd0);
      chk("reset_lo",    64'(bus.lo),    64'd0);
      chk("reset_flags", 64'({bus.busy, bus.done, bus.dz, bus.stall}), 64'd0);

      // Directed table
      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, 1'b1);
         wait_done($sformatf("vec%0d", i), lat, stalls);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
         check_result($sformatf("vec%0d", i));
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'd0);
      end

      // Random vectors against the model
      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i == 3) ? 32'd0 : $urandom;
         issue(rop, ra, rb, model(rop, ra, rb), 1'b1);
         wait_done($sformatf("rnd%0d", i), lat, stalls);
         check_result($sformatf("rnd%0d", i));
      end

      // Back-to-back: second start held while busy, accepted in the done cycle
      issue(2'b00, 32'h0000_1234, 32'h0000_5678, '{32'd0, 32'h0626_0060, 1'b0}, 1'b1);
      bus.op = 2'b11; bus.a = 32'hFFFF_FF9C; bus.b = 32'd7; bus.start = 1'b1;
      sb.push_back('{32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0});
      wait_done("b2b_first", lat, stalls);
      chk("b2b_first_latency", 64'(lat), 64'd34);
      chk("b2b_stall_cycles",  64'(stalls), 64'd33);
      chk("b2b_stall_at_done", 64'(bus.stall), 64'd0);
      check_result("b2b_first");
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
      chk("b2b_second_busy", 64'(bus.busy), 64'd1);
      wait_done("b2b_second", lat, stalls);
      chk("b2b_second_latency", 64'(lat), 64'd34);
      check_result("b2b_second");

      // MFHI/MFLO right after an accept waits until the done cycle
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'd0, 32'd1, 1'b0}, 1'b1);
      bus.mfhilo = 1'b1;
      wait_done("mf", lat, stalls);
      chk("mf_stall_cycles",  64'(stalls), 64'(lat - 1));
      chk("mf_stall_at_done", 64'(bus.stall), 64'd0);
      check_result("mf");
      bus.mfhilo = 1'b0;

      // Flush at RUN iteration 10: back to IDLE, no result, no done
      issue(2'b00, 32'd3, 32'd3, '{32'd0, 32'd9, 1'b0}, 1'b0);
      repeat (9) @(negedge clk);
      chk("flush_busy_before", 64'(bus.busy), 64'd1);
      bus.flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush_busy_after", 64'(bus.busy), 64'd0);
      chk("flush_hi", 64'(bus.hi), 64'(last.hi));
      chk("flush_lo", 64'(bus.lo), 64'(last.lo));
      chk("flush_dz", 64'(bus.dz), 64'(last.dz));
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) seen = 1'b1;
         @(negedge clk);
      end
      chk("flush_no_done", 64'(seen), 64'd0);

      // Flush beats start in IDLE
      bus.start = 1'b1; bus.flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("flush_prio_busy", 64'(bus.busy), 64'd0);

      // Asynchronous reset mid-RUN
      issue(2'b00, 32'h7, 32'h9, '{32'd0, 32'd63, 1'b0}, 1'b0);
      bus.mfhilo = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_stall_before", 64'(bus.stall), 64'd1);
      #2 clrn = 1'b0;
      #1;
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      chk("rst_flags", 64'({bus.busy, bus.done, bus.dz, bus.stall}), 64'd0);
      bus.mfhilo = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);

      // Recovery after reset
      e = model(2'b11, 32'hFFFF_FC18, 32'd33);
      issue(2'b11, 32'hFFFF_FC18, 32'd33, e, 1'b1);
      wait_done("post_rst", lat, stalls);
      chk("post_rst_latency", 64'(lat), 64'd34);
      check_result("post_rst");

      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
